buzzer_arbiter: RTL and testbench
=================================

Name: buzzer_arbiter

Overview:
Shares the single board buzzer between N_REQ sound requesters (reset button, feed, play, alarm, …).
- Each requester gets a fixed tone (half-period count) for a fixed duration, followed by a silent gap.
- Requests are latched, served one at a time by fixed priority (lowest index wins), and never pre-empted.
- Sits between the button/event logic and the buzzer pin, replacing per-source tone generators.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; ms prescaler divides by CLK_HZ/1000.
- N_REQ, 4, number of requesters (max 8).
- TONE_MS, 200, tone duration in ms.
- GAP_MS, 50, silent gap after each tone, in ms.
- HALF_PERIODS, package default table (N_REQ*20 bits), per-source 20-bit half-period in clk cycles; slice i = [20*i +: 20].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level requests; rising edge = one sound request.
- enable  in  1  0 = mute: abort playback and discard pending requests.
- buzzer  out  1  square-wave drive to the buzzer pin.
- busy  out  1  high during PLAY and GAP.
- grant_id  out  3  index of the source being served; valid while busy.
- done  out  1  one-cycle pulse at end of GAP.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, pending=0, req_q=0, all counters 0.
- Edge detect: req_q<=req each cycle; rise=req&~req_q; pending<=(pending&~clr)|rise.
  - Set wins over clear when the same bit rises and is granted in one cycle.
- Edges are detected even when enable=0 but are discarded (pending forced 0 while enable=0).
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If enable & |pending: select the lowest set index i, clear pending[i], grant_id<=i, load half<=HALF_PERIODS[i], clear tone_cnt/ms_cnt/dur_cnt, buzzer<=0, busy<=1, go PLAY.
  - Latency: busy rises at the second clk edge after req is first sampled high.
- PLAY:
  - tone_cnt counts 0..half-1; at half-1 it wraps to 0 and buzzer toggles.
  - First high level starts `half` cycles after PLAY entry.
  - ms_cnt counts 0..CLK_HZ/1000-1; wrap = ms_tick; dur_cnt increments on each ms_tick.
  - On the ms_tick that brings dur_cnt to TONE_MS: buzzer<=0, clear counters, go GAP.
  - PLAY lasts exactly TONE_MS*CLK_HZ/1000 cycles.
- GAP:
  - buzzer held 0; same ms counting.
  - On reaching GAP_MS: done<=1 for one cycle, busy<=0, go IDLE.
  - IDLE may grant the next request on the following edge; back-to-back service is allowed.
- Non-preemptive: requests arriving during PLAY/GAP only set pending; the highest priority among them is served next.
- enable=0 in PLAY/GAP: on the next edge go IDLE, buzzer=0, busy=0, no done, pending cleared.
- Repeated rise of a source already pending: absorbed (single entry).
- half=0 or 1 in table: illegal; buzzer behaviour is undefined, other timing unaffected.
- Widths: tone_cnt 20 bits; ms_cnt clog2(CLK_HZ/1000) bits; dur_cnt 16 bits. No overflow is possible for legal parameters.

Decomposition:
- Package buzzer_pkg holds:
  - FSM state encodings (IDLE/PLAY/GAP).
  - Default half-period constants: SRC_RESET 47_801 (523 Hz), SRC_FEED 42_589 (587 Hz), SRC_PLAY 37_936 (659 Hz), SRC_ALARM 31_888 (784 Hz) at 50 MHz.
  - Default HALF_PERIODS concatenation.
  - N_REQ_MAX.
- One natural sub-module: buzzer_tone_gen. It takes half, run and clear; it outputs the square wave.
  - The arbiter FSM, pending register and ms timer stay in the top module.

Test Plan:
Bench parameters: CLK_HZ=10_000 (10 cycles/ms), TONE_MS=4, GAP_MS=2, half-periods src0=2, src1=4, src2=6, src3=8.
1. Reset: rst_n=0 asynchronously mid-cycle -> buzzer, busy, done, grant_id all 0 immediately; req held high during reset release causes no request.
2. req[1] high for 1 cycle, enable=1 -> busy at 2nd edge, grant_id=1; buzzer toggles every 4 cycles for 40 cycles (5 full periods); then 20 cycles of 0; done pulses 1 cycle; busy falls.
3. req[3] and req[0] rise in the same cycle -> src0 served first (buzzer period 4 cycles), done, then src3 served immediately (period 16 cycles), second done.
4. req[0] rises while src2 in PLAY -> src2 completes the full 40+20 cycles, then src0 granted on the following edge.
5. enable=0 at PLAY cycle 15 with req[2] pending -> next edge buzzer=0, busy=0, no done; after enable=1 nothing plays until a new req edge.
6. req[1] toggled twice during its own PLAY -> exactly one extra service of src1 after the current one, not two.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer arbiter: FSM encodings, default tone table,
// and the priority-select helper.
package buzzer_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int HALF_W    = 20;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Half-period counts at 50 MHz: C5, D5, E5, G5
    localparam logic [HALF_W-1:0] SRC_RESET = 20'd47_801;
    localparam logic [HALF_W-1:0] SRC_FEED  = 20'd42_589;
    localparam logic [HALF_W-1:0] SRC_PLAY  = 20'd37_936;
    localparam logic [HALF_W-1:0] SRC_ALARM = 20'd31_888;

    localparam logic [4*HALF_W-1:0] HALF_PERIODS_DEFAULT =
        {SRC_ALARM, SRC_PLAY, SRC_FEED, SRC_RESET};

    function automatic logic [2:0] lowest_set(input logic [N_REQ_MAX-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_REQ_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// Square-wave generator: toggles its output every `half` clock cycles while
// run is high; clear forces the counter and output low.
module buzzer_tone_gen
    import buzzer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALF_W-1:0] half,
    input  logic              run,
    input  logic              clear,
    output logic              wave
);

    logic [HALF_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              wave_q, wave_d;

    // Next-state for the half-period counter and output level
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        wave_d     = wave_q;
        if (clear) begin
            tone_cnt_d = '0;
            wave_d     = 1'b0;
        end else if (run) begin
            if (tone_cnt_q == half - 20'd1) begin
                tone_cnt_d = '0;
                wave_d     = ~wave_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 20'd1;
            end
        end else begin
            tone_cnt_d = tone_cnt_q;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            wave_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            wave_q     <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Shares one buzzer among N_REQ sources: latches request edges, serves them
// one at a time by fixed priority with a tone of TONE_MS followed by a GAP_MS gap.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int N_REQ   = 4,
    parameter int TONE_MS = 200,
    parameter int GAP_MS  = 50,
    parameter logic [N_REQ*HALF_W-1:0] HALF_PERIODS = (N_REQ*HALF_W)'(HALF_PERIODS_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic             buzzer,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic             done
);

    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  req_q;
    logic [HALF_W-1:0] half_q, half_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [15:0]       dur_cnt_q, dur_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        grant_q, grant_d;

    logic [N_REQ-1:0]         rise_s, clr_s;
    logic [N_REQ_MAX-1:0]     pend_ext_s;
    logic [2:0]               sel_idx_s;
    logic                     ms_tick_s;
    logic                     tone_run_s, tone_clear_s;
    logic [N_REQ_MAX*HALF_W-1:0] half_ext_s;
    logic [HALF_W-1:0]        half_tab_s [N_REQ_MAX];

    assign rise_s    = req & ~req_q;
    assign ms_tick_s = (ms_cnt_q == MS_W'(MS_DIV - 1));
    assign sel_idx_s = lowest_set(pend_ext_s);

    // Widen pending and the tone table to the full 8-source index space
    always_comb begin
        pend_ext_s = '0;
        pend_ext_s[N_REQ-1:0] = pending_q;
        half_ext_s = '0;
        half_ext_s[N_REQ*HALF_W-1:0] = HALF_PERIODS;
        for (int i = 0; i < N_REQ_MAX; i++) begin
            half_tab_s[i] = half_ext_s[HALF_W*i +: HALF_W];
        end
    end

    // Arbiter FSM, ms timer and pending-request bookkeeping
    always_comb begin
        state_d      = state_q;
        clr_s        = '0;
        half_d       = half_q;
        ms_cnt_d     = ms_cnt_q;
        dur_cnt_d    = dur_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        grant_d      = grant_q;
        tone_run_s   = 1'b0;
        tone_clear_s = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (enable && (|pending_q)) begin
                    clr_s     = N_REQ'(1'b1) << sel_idx_s;
                    grant_d   = sel_idx_s;
                    half_d    = half_tab_s[sel_idx_s];
                    ms_cnt_d  = '0;
                    dur_cnt_d = 16'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_PLAY;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_PLAY, ST_GAP: begin
                if (!enable) begin
                    ms_cnt_d  = '0;
                    dur_cnt_d = 16'd0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (ms_tick_s && (state_q == ST_PLAY) && (dur_cnt_q == 16'(TONE_MS - 1))) begin
                    ms_cnt_d  = '0;
                    dur_cnt_d = 16'd0;
                    state_d   = ST_GAP;
                end else if (ms_tick_s && (state_q == ST_GAP) && (dur_cnt_q == 16'(GAP_MS - 1))) begin
                    ms_cnt_d  = '0;
                    dur_cnt_d = 16'd0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    if (ms_tick_s) begin
                        ms_cnt_d  = '0;
                        dur_cnt_d = dur_cnt_q + 16'd1;
                    end else begin
                        ms_cnt_d  = ms_cnt_q + MS_W'(1);
                    end
                    tone_run_s   = (state_q == ST_PLAY);
                    tone_clear_s = (state_q != ST_PLAY);
                end
            end
            default: begin
                ms_cnt_d  = '0;
                dur_cnt_d = 16'd0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // A new edge on a just-granted source must survive its own clear
        pending_d = enable ? ((pending_q & ~clr_s) | rise_s) : '0;
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            req_q     <= '0;
            half_q    <= '0;
            ms_cnt_q  <= '0;
            dur_cnt_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            grant_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req;
            half_q    <= half_d;
            ms_cnt_q  <= ms_cnt_d;
            dur_cnt_q <= dur_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            grant_q   <= grant_d;
        end
    end

    buzzer_tone_gen u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .half  (half_q),
        .run   (tone_run_s),
        .clear (tone_clear_s),
        .wave  (buzzer)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with 10 cycles/ms, 4 ms tone, 2 ms gap.
module tb_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       enable;
    logic       buzzer;
    logic       busy;
    logic [2:0] grant_id;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buzzer_arbiter #(
        .CLK_HZ       (10_000),
        .N_REQ        (4),
        .TONE_MS      (4),
        .GAP_MS       (2),
        .HALF_PERIODS ({20'd8, 20'd6, 20'd4, 20'd2})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .enable   (enable),
        .buzzer   (buzzer),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic bz, input logic bs, input logic dn, input logic [2:0] gid);
        chk({tag, "_buzzer"}, 32'(buzzer), 32'(bz));
        chk({tag, "_busy"}, 32'(busy), 32'(bs));
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_grant"}, 32'(grant_id), 32'(gid));
    endtask

    task automatic expect_grant(input logic [2:0] src);
        step(1);
        chk($sformatf("grant%0d_busy", src), 32'(busy), 32'd1);
        chk($sformatf("grant%0d_id", src), 32'(grant_id), 32'(src));
        chk($sformatf("grant%0d_buzzer", src), 32'(buzzer), 32'd0);
        chk($sformatf("grant%0d_done", src), 32'(done), 32'd0);
    endtask

    // One-cycle request pulse; busy must appear on the second edge
    task automatic pulse_and_grant(input logic [3:0] mask, input logic [2:0] src);
        req = mask;
        step(1);
        chk("pre_grant_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        expect_grant(src);
    endtask

    // Walks edges 1..60 after PLAY entry; optional request pulses at inj_a/inj_b
    task automatic serve(input logic [2:0] src, input int half, input int inj_a, input int inj_b,
                         input logic [3:0] mask);
        int exp_bz;
        for (int k = 1; k <= 60; k++) begin
            step(1);
            exp_bz = (k < 40) ? ((k / half) % 2) : 0;
            chk($sformatf("s%0d_buzzer_k%0d", src, k), 32'(buzzer), 32'(exp_bz));
            chk($sformatf("s%0d_busy_k%0d", src, k), 32'(busy), (k < 60) ? 32'd1 : 32'd0);
            chk($sformatf("s%0d_done_k%0d", src, k), 32'(done), (k == 60) ? 32'd1 : 32'd0);
            if (k < 60) chk($sformatf("s%0d_grant_k%0d", src, k), 32'(grant_id), 32'(src));
            req = ((k == inj_a) || (k == inj_b)) ? mask : 4'b0000;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        enable = 1'b0;
        step(2);
        outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step(1);

        // 1: asynchronous reset mid-playback, then req held high through release
        pulse_and_grant(4'b0010, 3'd1);
        step(5);
        outs("pre_async", 1'b1, 1'b1, 1'b0, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        outs("async_rst", 1'b0, 1'b0, 1'b0, 3'd0);
        req    = 4'b1111;
        enable = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("held_req_busy", 32'(busy), 32'd0);
        end
        req = 4'b0000;
        step(2);
        chk("held_req_idle", 32'(busy), 32'd0);

        // 2: single service of src1
        pulse_and_grant(4'b0010, 3'd1);
        serve(3'd1, 4, -1, -1, 4'b0000);

        // 3: simultaneous src0 and src3, priority then back-to-back
        pulse_and_grant(4'b1001, 3'd0);
        serve(3'd0, 2, -1, -1, 4'b0000);
        expect_grant(3'd3);
        serve(3'd3, 8, -1, -1, 4'b0000);
        step(1);
        chk("after_src3_busy", 32'(busy), 32'd0);

        // 4: no pre-emption of src2 by src0
        pulse_and_grant(4'b0100, 3'd2);
        serve(3'd2, 6, 10, -1, 4'b0001);
        expect_grant(3'd0);
        serve(3'd0, 2, -1, -1, 4'b0000);
        step(1);
        chk("after_t4_busy", 32'(busy), 32'd0);

        // 5: mute during PLAY discards playback and pending src2
        pulse_and_grant(4'b0001, 3'd0);
        for (int k = 1; k <= 14; k++) begin
            step(1);
            chk($sformatf("mute_buzzer_k%0d", k), 32'(buzzer), 32'((k / 2) % 2));
            chk($sformatf("mute_busy_k%0d", k), 32'(busy), 32'd1);
            req = (k == 3) ? 4'b0100 : 4'b0000;
        end
        enable = 1'b0;
        step(1);
        chk("mute_buzzer", 32'(buzzer), 32'd0);
        chk("mute_busy", 32'(busy), 32'd0);
        chk("mute_done", 32'(done), 32'd0);
        step(1);
        chk("mute_done2", 32'(done), 32'd0);
        chk("mute_busy2", 32'(busy), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("unmute_idle_busy", 32'(busy), 32'd0);
        end
        pulse_and_grant(4'b0100, 3'd2);
        serve(3'd2, 6, -1, -1, 4'b0000);
        step(1);
        chk("after_t5_busy", 32'(busy), 32'd0);

        // 6: repeated edges of src1 during its own PLAY collapse to one entry
        pulse_and_grant(4'b0010, 3'd1);
        serve(3'd1, 4, 5, 12, 4'b0010);
        expect_grant(3'd1);
        serve(3'd1, 4, -1, -1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("single_repeat_busy", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
